// File: rtl/msk_inv_mixcolumn_serial.sv
// -----------------------------------------------------------------------------
// msk_inv_mixcolumn_serial
//
// Purpose:
//   Masked, byte-serial InvMixColumns column engine for the decryption
//   datapath. It accepts one masked state byte per cycle, in row order 0..3.
//   Each share is processed on its own: xtime chains form the x9/xb/xd/xe
//   multiples, and four per-share accumulators build the output column. A
//   finished column is placed in a one-deep output register with a
//   valid/ready handshake. The transform is linear per share, so it needs no
//   randomness and never combines two shares.
//
// Parameters:
//   d          number of shares (>= 1)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input byte valid
//   in_ready   byte accepted when in_valid & in_ready
//   in_byte    masked byte, bit-interleaved: bit i of share j at [i*d+j]
//   out_valid  masked column available
//   out_ready  column consumed when out_valid & out_ready
//   out_col    masked column; row r byte at [8*d*r +: 8*d], same interleaving
// -----------------------------------------------------------------------------
module msk_inv_mixcolumn_serial #(
    parameter int unsigned d = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*d-1:0]    in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*d-1:0]   out_col
);

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns the four InvMixColumns multiples of b, indexed by the
    // coefficient slot k: k=0 -> x0e, k=1 -> x0b, k=2 -> x0d, k=3 -> x09.
    // Byte c contributes to output row r with slot (c - r) mod 4.
    function automatic logic [3:0][7:0] inv_products(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [3:0][7:0] p;
        x2   = xtime(b);
        x4   = xtime(x2);
        x8   = xtime(x4);
        p[0] = x8 ^ x4 ^ x2;   // x0e
        p[1] = x8 ^ x2 ^ b;    // x0b
        p[2] = x8 ^ x4 ^ b;    // x0d
        p[3] = x8 ^ b;         // x09
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]                 r_cnt;       // row index of the next byte
    logic [3:0][d-1:0][7:0]     r_acc;       // [row][share] partial sums
    logic                       r_out_valid;
    logic [32*d-1:0]            r_out_col;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [d-1:0][7:0]          w_share;     // de-interleaved input shares
    logic [d-1:0][3:0][7:0]     w_prod;      // [share][slot] products
    logic [3:0][d-1:0][7:0]     w_acc_next;  // accumulators after this byte
    logic [32*d-1:0]            w_col_next;  // w_acc_next, re-interleaved
    logic                       w_last;
    logic                       w_accept;
    logic                       w_load;

    // NOTE: every signal written in an always_comb block gets a default
    // first, so no path through the block can leave it unassigned and
    // infer a latch.
    always_comb begin : p_deinterleave
        w_share = '0;
        for (int j = 0; j < int'(d); j++) begin
            for (int i = 0; i < 8; i++) begin
                w_share[j][i] = in_byte[i*int'(d) + j];
            end
        end
    end

    always_comb begin : p_products
        w_prod = '0;
        for (int j = 0; j < int'(d); j++) begin
            w_prod[j] = inv_products(w_share[j]);
        end
    end

    // At row 0 the accumulators are loaded, not XORed. A new column
    // therefore needs no separate clearing cycle, and it overwrites
    // whatever the previous column left behind.
    always_comb begin : p_accumulate
        w_acc_next = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < int'(d); j++) begin
                w_acc_next[r][j] = ((r_cnt == 2'd0) ? 8'h00 : r_acc[r][j])
                                 ^ w_prod[j][r_cnt - 2'(r)];
            end
        end
    end

    always_comb begin : p_interleave
        w_col_next = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < int'(d); j++) begin
                for (int i = 0; i < 8; i++) begin
                    w_col_next[8*int'(d)*r + i*int'(d) + j] = w_acc_next[r][j][i];
                end
            end
        end
    end

    // Only the closing byte of a column needs space in the output register.
    // Bytes 0..2 of the next column are always accepted, so they can overlap
    // with a pending output.
    assign w_last   = (r_cnt == 2'd3);
    assign in_ready = !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_last;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) only, so
    // every register samples values from before the clock edge, regardless
    // of the order of the statements.
    always_ff @(posedge clk or negedge rst_n) begin : p_acc_reg
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 2'd1;
            r_acc <= w_acc_next;
        end
    end

    // A new column may load in the same cycle that the old one is consumed.
    // In that case out_valid stays high and carries the new data.
    always_ff @(posedge clk or negedge rst_n) begin : p_out_reg
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_col   <= w_col_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_col   = r_out_col;

endmodule

// File: tb/tb_msk_inv_mixcolumn_serial.sv
// -----------------------------------------------------------------------------
// tb_msk_inv_mixcolumn_serial
//
// Directed bench for msk_inv_mixcolumn_serial. It drives a two-share build
// (d=2) and an unmasked build (d=1) from the same clock and reset. Inputs
// change on the falling edge, and outputs are sampled on the falling edge,
// away from the rising edge where the design captures data.
// -----------------------------------------------------------------------------
module tb_msk_inv_mixcolumn_serial;

    logic        clk;
    logic        rst_n;

    // d = 2 instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_col;

    // d = 1 instance
    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  in_byte1;
    logic        out_valid1;
    logic        out_ready1;
    logic [31:0] out_col1;

    int n_checks;
    int n_errors;

    logic [7:0] col_v [4];
    logic [7:0] col_m [4];

    msk_inv_mixcolumn_serial #(.d(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col)
    );

    msk_inv_mixcolumn_serial #(.d(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_byte   (in_byte1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_col   (out_col1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two-share encoding: share1 = mask, share0 = value ^ mask.
    function automatic logic [15:0] enc(input logic [7:0] v, input logic [7:0] m);
        logic [15:0] b;
        for (int i = 0; i < 8; i++) begin
            b[2*i]   = v[i] ^ m[i];
            b[2*i+1] = m[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] share_of(input logic [63:0] c, input int j);
        logic [31:0] s;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 8; i++)
                s[8*r+i] = c[16*r + 2*i + j];
        return s;
    endfunction

    function automatic logic [31:0] recomb(input logic [63:0] c);
        return share_of(c, 0) ^ share_of(c, 1);
    endfunction

    // Reference GF(2^8) multiply: shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Reference InvMixColumns on a column given as four bytes (row 0 first).
    // The result packs row r into bits [8r+7:8r].
    function automatic logic [31:0] inv_mix(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        logic [31:0] o;
        o[7:0]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[15:8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[23:16] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[31:24] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        return o;
    endfunction

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_byte    = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_byte1   = '0;
        out_ready1 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_col", out_col, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_d1_out_col", 64'(out_col1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) Single column 8e,4d,a1,bc, constant mask 0x5a, and d=1 in parallel.
        col_v = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_byte   = enc(col_v[k], 8'h5a);
            in_valid1 = 1'b1;
            in_byte1  = col_v[k];
            #1;
            check("t1_in_ready", 64'(in_ready), 64'd1);
            if (k == 3) check("t1_early_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_col", 64'(recomb(out_col)), 64'h455313db);
        check("t1_share1", 64'(share_of(out_col, 1)), 64'h5a5a5a5a);
        check("t1_d1_valid", 64'(out_valid1), 64'd1);
        check("t1_d1_col", 64'(out_col1), 64'h455313db);
        @(negedge clk);
        check("t1_valid_clear", 64'(out_valid), 64'd0);

        // 2) Back-to-back columns, no gaps.
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                check("t2_col0_valid", 64'(out_valid), 64'd1);
                check("t2_col0", 64'(recomb(out_col)), 64'h5c220af2);
            end
            if (k > 4) check("t2_gap_valid", 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            case (k)
                0: in_byte = enc(8'h9f, 8'h33);
                1: in_byte = enc(8'hdc, 8'h33);
                2: in_byte = enc(8'h58, 8'h33);
                3: in_byte = enc(8'h9d, 8'h33);
                default: in_byte = enc(8'h01, 8'hc4);
            endcase
            #1;
            check("t2_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t2_col1_valid", 64'(out_valid), 64'd1);
        check("t2_col1", 64'(recomb(out_col)), 64'h01010101);
        @(negedge clk);

        // 3) Backpressure: first column held while the second one is fed.
        col_v = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_byte  = enc(col_v[k], 8'ha5);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("t3_a_valid", 64'(out_valid), 64'd1);
        check("t3_a_col", 64'(recomb(out_col)), 64'h455313db);
        col_v = '{8'h9f, 8'hdc, 8'h58, 8'h9d};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_byte  = enc(col_v[k], 8'ha5);
            #1;
            check("t3_b_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            check("t3_a_hold_valid", 64'(out_valid), 64'd1);
            check("t3_a_hold_col", 64'(recomb(out_col)), 64'h455313db);
        end
        in_byte = enc(col_v[3], 8'ha5);
        #1;
        check("t3_stall_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("t3_stall_ready2", 64'(in_ready), 64'd0);
        check("t3_stall_col", 64'(recomb(out_col)), 64'h455313db);
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_b_valid", 64'(out_valid), 64'd1);
        check("t3_b_col", 64'(recomb(out_col)), 64'h5c220af2);
        check("t3_b_share1", 64'(share_of(out_col, 1)), 64'ha5a5a5a5);
        @(negedge clk);
        check("t3_b_clear", 64'(out_valid), 64'd0);

        // 4) Random gaps and random per-byte masks, column c6 x4.
        for (int k = 0; k < 4; k++) begin
            col_m[k] = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_byte  = 16'($urandom);
                @(negedge clk);
                check("t4_gap_valid", 64'(out_valid), 64'd0);
            end
            in_valid = 1'b1;
            in_byte  = enc(8'hc6, col_m[k]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_col", 64'(recomb(out_col)), 64'hc6c6c6c6);
        check("t4_share1", 64'(share_of(out_col, 1)),
              64'(inv_mix(col_m[0], col_m[1], col_m[2], col_m[3])));
        check("t4_share0", 64'(share_of(out_col, 0)),
              64'(inv_mix(8'hc6 ^ col_m[0], 8'hc6 ^ col_m[1],
                          8'hc6 ^ col_m[2], 8'hc6 ^ col_m[3])));
        @(negedge clk);

        // 5) Reset in the middle of a column, then a clean column.
        in_valid = 1'b1;
        in_byte  = enc(8'h11, 8'h00);
        @(negedge clk);
        in_byte  = enc(8'h22, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_col", out_col, 64'd0);
        check("t5_rst_d1_valid", 64'(out_valid1), 64'd0);
        check("t5_rst_d1_col", 64'(out_col1), 64'd0);
        @(negedge clk);
        check("t5_rst_hold_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        col_v = '{8'hd5, 8'hd5, 8'hd7, 8'hd6};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_byte  = enc(col_v[k], 8'h3c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_col", 64'(recomb(out_col)), 64'hd5d4d4d4);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msk_inv_mixcolumn_serial.md
Name: msk_inv_mixcolumn_serial

Overview:
- Masked, byte-serial InvMixColumns column engine for the decryption datapath.
- Consumes one masked state byte per cycle. Forms the per-share x9/xb/xd/xe products internally with share-wise xtime chains, and accumulates the four output bytes of the column share-wise.
- Emits the full masked 32-bit column through a one-deep output register with valid/ready handshake.
- Purely linear per share: no randomness, no cross-share mixing.

Parameters:
d, 2, number of shares (≥1).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input byte valid.
in_ready  output  1  byte accepted when in_valid & in_ready.
in_byte  input  8*d  masked byte, bit-interleaved: bit i of share j at [i*d+j].
out_valid  output  1  masked column available.
out_ready  input  1  column consumed when out_valid & out_ready.
out_col  output  32*d  masked column; row r byte at [8*d*r +: 8*d], same interleaving.

Behaviour:
- Reset (async, rst_n=0): cnt=0, accumulators=0, out_valid=0, out_col=0. Any partial column is discarded.
- Byte order: row 0 first, then rows 1, 2 and 3. cnt (2 bits) holds the index c of the next expected byte.
- Per share, on acceptance of byte c:
  - x2 = xtime(b), x4 = xtime(x2), x8 = xtime(x4), where xtime = shift left, XOR 0x1b if MSB set.
  - x9 = x8^b; xb = x8^x2^b; xd = x8^x4^b; xe = x8^x4^x2.
- Coefficient of byte c into output row r is K[(c-r) mod 4], with K = {e, b, d, 9}.
- Accumulator update:
  - When cnt==0, each acc_r is loaded with its contribution (not XORed), so no clearing cycle is needed.
  - Otherwise acc_r ^= contribution.
  - All XORs are share-separated.
- cnt increments on each accepted byte and wraps 3→0.
- On acceptance at cnt==3:
  - out_col <= {acc_3..acc_0} with the final contributions applied in the same cycle.
  - out_valid <= 1.
  - Latency: column valid the cycle after the 4th byte is accepted.
- Output register:
  - Holds its value while out_valid & !out_ready.
  - Clears out_valid on handshake unless a new column loads in the same cycle; in that case out_valid stays 1 with the new data.
- in_ready = !(cnt==3 & out_valid & !out_ready).
  - Bytes 0–2 of the next column are always accepted, so a new column overlaps with a pending output.
  - The 4th byte stalls only while the output is occupied and not draining.
  - in_ready is combinational from out_ready. No combinational path from in_valid to out_*.
- Throughput: one byte per cycle sustained; one column per 4 cycles when out_ready=1.
- in_valid=0 holds cnt and accumulators; gaps between bytes are allowed anywhere.
- out_col is undefined-free: it holds the last loaded column, or 0 after reset.
- Security:
  - Share j of out_col depends only on share j of inputs.
  - Accumulators are registered per share, with no combinational recombination.

Test Plan:
- d=2, share1 = mask 0x5a for all bytes, share0 = value^mask, bytes 8e,4d,a1,bc, out_ready=1 → out_valid one cycle after 4th byte; recombined column db,13,53,45.
- Back-to-back columns 9f,dc,58,9d then 01,01,01,01 with no gaps → outputs f2,0a,22,5c then 01,01,01,01, each 4 cycles apart; in_ready stays 1 throughout.
- Backpressure: out_ready=0 after the first column completes and the second column is fed → bytes 0–2 accepted, in_ready=0 at cnt==3; first column stays stable on out_col. Raise out_ready → 4th byte accepted in the same cycle, second column appears next cycle, no data loss.
- Random in_valid gaps with column c6,c6,c6,c6 and random masks per byte → recombined output c6,c6,c6,c6; per-share output equals InvMixColumns of each share's stream.
- Assert rst_n=0 after 2 bytes of a column, release, then feed a full column d5,d5,d7,d6 → out_valid=0 during reset; output d4,d4,d4,d5 with no contamination from the aborted bytes.
- d=1 build: unmasked stream 8e,4d,a1,bc → db,13,53,45; reset values out_col=0 and out_valid=0 checked immediately after async reset assertion, without a clock edge.
